// File: rtl/sic1_out_capture.sv
// Purpose : capture SIC-1 CPU output bytes into the host clock domain and queue them for a reader.
// Latency : byte visible on rd_data/rd_valid SYNC_STAGES clocks after the strobe low level is first sampled.
// Backpr. : none toward the CPU; a byte arriving while the FIFO is full (and not popped) is dropped and flags overflow.
//
// Ports:
//   clk, rst_n          host clock, asynchronous active-low reset
//   cpu_out             CPU output byte, stable while the strobe is low
//   cpu_out_strobe_n    CPU output strobe, active low
//   cpu_halted          CPU halted flag, active high
//   clear               synchronous flush of FIFO, sticky flags and byte counter
//   rd_en               pop the head entry (ignored when empty)
//   rd_data             head byte, show-ahead (reads 0 when empty)
//   rd_valid, full      FIFO non-empty / holds DEPTH entries
//   level               number of entries held
//   overflow            sticky: a byte was dropped because the FIFO was full
//   halted_seen         sticky: synchronized halt has been observed
//   byte_count          bytes accepted into the FIFO, wraps silently
module sic1_out_capture #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 cpu_out,
    input  logic                       cpu_out_strobe_n,
    input  logic                       cpu_halted,
    input  logic                       clear,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       halted_seen,
    output logic [CNT_W-1:0]           byte_count
);

    localparam int AW = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Synchronizers. All three chains have the same depth so the data
    // word leaving the last stage lines up with its strobe.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] strobe_sync;
    logic [SYNC_STAGES-1:0] halt_sync;
    logic [7:0]             data_sync [SYNC_STAGES];
    logic                   strobe_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_sync <= '1;
            halt_sync   <= '0;
            strobe_prev <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync[i] <= 8'h00;
            end
        end else begin
            strobe_sync  <= {strobe_sync[SYNC_STAGES-2:0], cpu_out_strobe_n};
            halt_sync    <= {halt_sync[SYNC_STAGES-2:0], cpu_halted};
            strobe_prev  <= strobe_sync[SYNC_STAGES-1];
            data_sync[0] <= cpu_out;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sync[i] <= data_sync[i-1];
            end
        end
    end

    // Falling edge of the synchronized strobe: one event per low period,
    // however long the CPU holds it.
    logic       cap_evt;
    logic [7:0] cap_dat;
    logic       halt_s;

    assign cap_evt = strobe_prev & ~strobe_sync[SYNC_STAGES-1];
    assign cap_dat = data_sync[SYNC_STAGES-1];
    assign halt_s  = halt_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FIFO: circular buffer with pointers one bit wider than the index so
    // full and empty are distinguishable without a separate counter.
    // ------------------------------------------------------------------
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        pop;
    logic        push;
    logic        drop;

    assign level    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (level == (AW+1)'(DEPTH));
    assign rd_valid = ~empty;
    // Head is gated so the output reads 0 out of reset and after a flush.
    assign rd_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    assign pop  = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = cap_evt & (~full | pop);
    assign drop = cap_evt & full & ~pop;

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr[AW-1:0]] <= cap_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow    <= 1'b0;
            halted_seen <= 1'b0;
            byte_count  <= '0;
        end else if (clear) begin
            // Edge-detect state is left alone so a strobe already low does
            // not produce a second event after the flush.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow    <= 1'b0;
            halted_seen <= 1'b0;
            byte_count  <= '0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + (AW+1)'(1);
                byte_count <= byte_count + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (halt_s) begin
                halted_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sic1_out_capture.sv
module tb_sic1_out_capture;

    logic        clk;
    logic        rst_n;
    logic [7:0]  cpu_out;
    logic        cpu_out_strobe_n;
    logic        cpu_halted;
    logic        clear;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        full;
    logic [3:0]  level;
    logic        overflow;
    logic        halted_seen;
    logic [15:0] byte_count;

    int tests_run;
    int tests_failed;

    sic1_out_capture #(
        .DEPTH      (8),
        .SYNC_STAGES(2),
        .CNT_W      (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_out         (cpu_out),
        .cpu_out_strobe_n(cpu_out_strobe_n),
        .cpu_halted      (cpu_halted),
        .clear           (clear),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .full            (full),
        .level           (level),
        .overflow        (overflow),
        .halted_seen     (halted_seen),
        .byte_count      (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe_byte(input logic [7:0] b, input int lo, input int hi);
        cpu_out          = b;
        cpu_out_strobe_n = 1'b0;
        repeat (lo) tick();
        cpu_out_strobe_n = 1'b1;
        repeat (hi) tick();
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        rst_n            = 1'b0;
        cpu_out          = 8'h00;
        cpu_out_strobe_n = 1'b1;
        cpu_halted       = 1'b0;
        clear            = 1'b0;
        rd_en            = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_halted_seen", halted_seen, 0);
        chk("rst_byte_count", byte_count, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Two bytes, latency of the first measured edge by edge
        cpu_out          = 8'h48;
        cpu_out_strobe_n = 1'b0;
        tick();
        chk("lat_k0_valid", rd_valid, 0);
        tick();
        chk("lat_k1_valid", rd_valid, 0);
        tick();
        chk("lat_k2_valid", rd_valid, 1);
        chk("lat_k2_data", rd_data, 8'h48);
        cpu_out_strobe_n = 1'b1;
        repeat (3) tick();
        strobe_byte(8'h69, 3, 3);
        chk("two_level", level, 2);
        chk("two_head", rd_data, 8'h48);
        pop1();
        chk("pop1_data", rd_data, 8'h69);
        chk("pop1_level", level, 1);
        pop1();
        chk("pop2_valid", rd_valid, 0);
        chk("two_byte_count", byte_count, 2);

        // Pop on an empty FIFO is ignored
        pop1();
        chk("empty_pop_level", level, 0);
        chk("empty_pop_count", byte_count, 2);

        // Long strobe gives exactly one entry
        do_clear();
        strobe_byte(8'h55, 20, 3);
        chk("long_level", level, 1);
        chk("long_data", rd_data, 8'h55);
        chk("long_count", byte_count, 1);

        // Overflow: 10 bytes into 8 slots
        do_clear();
        for (int i = 0; i < 10; i++) strobe_byte(8'(i), 2, 2);
        chk("ovf_full", full, 1);
        chk("ovf_level", level, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", byte_count, 8);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain", rd_data, 32'(i));
            pop1();
        end
        chk("ovf_drained", rd_valid, 0);

        // Full FIFO with a pop on the cycle the 9th byte lands
        do_clear();
        for (int i = 0; i < 8; i++) strobe_byte(8'(i), 2, 2);
        chk("fp_full_before", full, 1);
        cpu_out          = 8'h08;
        cpu_out_strobe_n = 1'b0;
        tick();
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("fp_level", level, 8);
        chk("fp_overflow", overflow, 0);
        chk("fp_head", rd_data, 8'h01);
        chk("fp_count", byte_count, 9);
        cpu_out_strobe_n = 1'b1;
        repeat (3) tick();
        for (int i = 1; i <= 8; i++) begin
            chk("fp_drain", rd_data, 32'(i));
            pop1();
        end

        // Halt pulse, sticky flag, then clear of everything
        do_clear();
        for (int i = 0; i < 9; i++) strobe_byte(8'(8'h30 + i), 2, 2);
        chk("pre_halt_ovf", overflow, 1);
        cpu_halted = 1'b1;
        tick();
        tick();
        chk("halt_k1", halted_seen, 0);
        tick();
        chk("halt_k2", halted_seen, 1);
        cpu_halted = 1'b0;
        repeat (5) tick();
        chk("halt_sticky", halted_seen, 1);
        do_clear();
        chk("clr_halted", halted_seen, 0);
        chk("clr_level", level, 0);
        chk("clr_overflow", overflow, 0);
        chk("clr_count", byte_count, 0);
        chk("clr_valid", rd_valid, 0);
        chk("clr_full", full, 0);

        // Clear while halt is still high: flag comes back next cycle
        cpu_halted = 1'b1;
        repeat (4) tick();
        do_clear();
        chk("clr_hold_halt_0", halted_seen, 0);
        tick();
        chk("clr_hold_halt_1", halted_seen, 1);
        cpu_halted = 1'b0;
        repeat (3) tick();
        do_clear();

        // Asynchronous reset with entries queued
        for (int i = 0; i < 3; i++) strobe_byte(8'(8'hC0 + i), 2, 2);
        chk("pre_rst_level", level, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", rd_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_data", rd_data, 0);
        chk("arst_count", byte_count, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        strobe_byte(8'hA5, 3, 3);
        chk("post_rst_level", level, 1);
        chk("post_rst_data", rd_data, 8'hA5);
        chk("post_rst_count", byte_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests run %0d", tests_run);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sic1_out_capture.md
Name: sic1_out_capture

Overview:
Host-side capture block for the SIC-1 CPU output port. It monitors the CPU's byte output bus, its active-low output strobe and its halted flag, then synchronizes them into the host clock domain. Each strobed byte is queued in a small show-ahead FIFO for a host reader. It also latches halt and overflow status and counts captured bytes, so benches and FPGA harnesses can drain program output without cycle-exact polling.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=2)
SYNC_STAGES, 2, synchronizer flops on strobe/halt/data (>=2)
CNT_W, 16, width of total captured-byte counter

Ports:
clk  input  1  host clock
rst_n  input  1  asynchronous active-low reset
cpu_out  input  8  CPU output byte (uo_out)
cpu_out_strobe_n  input  1  CPU output strobe, active low (uio_out[4] gated by uio_oe[4])
cpu_halted  input  1  CPU halted, active high (uio_out[1] gated by uio_oe[1])
clear  input  1  synchronous flush of FIFO, flags and counter
rd_en  input  1  pop head entry
rd_data  output  8  head byte (show-ahead)
rd_valid  output  1  FIFO non-empty
full  output  1  FIFO holds DEPTH entries
level  output  $clog2(DEPTH)+1  entries held
overflow  output  1  sticky: byte dropped because FIFO full
halted_seen  output  1  sticky: synchronized halt observed
byte_count  output  CNT_W  bytes accepted into FIFO, wraps

Behaviour:
- Reset is asynchronous and active-low on rst_n, single clock clk. On reset all outputs are 0: rd_data=0, rd_valid=0, full=0, level=0, overflow=0, halted_seen=0, byte_count=0. Synchronizer flops for strobe_n reset to 1; for halt and data they reset to 0. The previous-strobe register resets to 1.
- Synchronization: cpu_out_strobe_n, cpu_halted and cpu_out each pass through SYNC_STAGES flops. The chains are identical, so data stays aligned with its strobe. The CPU holds cpu_out stable for the whole time strobe is low.
- Edge detect: a registered copy of the last sync stage is compared with the stage itself. A capture event is prev=1 and sync=0, i.e. a falling edge. A strobe held low produces exactly one event. A low pulse shorter than one clk period may be missed; this is permitted.
- Latency: the strobe low level is first sampled at edge k. The byte is written at edge k+SYNC_STAGES, and rd_valid/rd_data are valid after that edge. With SYNC_STAGES=2 this is 2 clocks.
- FIFO: circular buffer, pointers one bit wider than the index. rd_data always shows the head entry; its value is don't-care when rd_valid=0. A pop happens when rd_en=1 and rd_valid=1. rd_en while empty is ignored, with no underflow flag.
- Simultaneous push and pop:
  - Non-empty, non-full FIFO: both happen, level unchanged.
  - Empty FIFO: push only; the pop is ignored.
  - Full FIFO: the pop frees a slot, the push is accepted, level stays DEPTH and overflow is not set.
- Full without pop: the byte is dropped, overflow is set, byte_count is unchanged.
- byte_count increments on every accepted push. It wraps from 2^CNT_W-1 to 0 with no flag.
- halted_seen is set when the synchronized halt is 1, then holds until clear or reset. It does not depend on the FIFO being drained.
- clear (synchronous, priority over everything that cycle):
  - Empties the FIFO and zeroes level, overflow, halted_seen and byte_count.
  - A capture event in the same cycle is discarded.
  - Synchronizer and edge-detect state is not cleared, so a strobe already low does not re-trigger.
  - If the halt input is still high, halted_seen re-sets on the next cycle.
- Reset mid-transfer: FIFO contents are lost. The previous-strobe register resets to 1, so a strobe still low after reset release gives one capture event.

Test Plan:
- Reset, then strobe bytes 0x48,0x69 (strobe low 3 clks, high 3 clks each) -> rd_valid rises 2 clks after first low sample; rd_data=0x48; pop -> 0x69; pop -> rd_valid=0; byte_count=2.
- Strobe held low 20 clks with cpu_out=0x55 -> exactly one entry, level=1.
- 10 strobes 0x00..0x09 with no reads, DEPTH=8 -> full=1, level=8, overflow=1, byte_count=8; drain yields 0x00..0x07 in order.
- Full FIFO plus rd_en held on the cycle the 9th capture lands -> 0x00 popped, 0x08 accepted, level=8, overflow=0.
- cpu_halted pulsed high 3 clks -> halted_seen=1 two clks later and stays 1; clear -> all flags, level and byte_count=0.
- Mid-stream assert rst_n=0 asynchronously with 3 entries queued -> outputs immediately 0; after release, fresh strobe 0xA5 is captured as the sole entry.
